// File: rtl/exec_pkg.sv
// Shared widths and opcode encodings for the execute-stage ALU/CSR datapath.
package exec_pkg;

    localparam int XLEN    = 64;
    localparam int ALUOP_W = 5;
    localparam int CSROP_W = 2;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 5'd2;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 5'd3;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 5'd4;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 5'd5;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 5'd6;
    localparam logic [ALUOP_W-1:0] ALU_SRA  = 5'd7;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 5'd8;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 5'd9;
    localparam logic [ALUOP_W-1:0] ALU_ADDW = 5'd10;
    localparam logic [ALUOP_W-1:0] ALU_SUBW = 5'd11;
    localparam logic [ALUOP_W-1:0] ALU_SLLW = 5'd12;
    localparam logic [ALUOP_W-1:0] ALU_SRLW = 5'd13;
    localparam logic [ALUOP_W-1:0] ALU_SRAW = 5'd14;
    localparam logic [ALUOP_W-1:0] ALU_EQ   = 5'd15;
    localparam logic [ALUOP_W-1:0] ALU_NE   = 5'd16;
    localparam logic [ALUOP_W-1:0] ALU_LT   = 5'd17;
    localparam logic [ALUOP_W-1:0] ALU_GE   = 5'd18;
    localparam logic [ALUOP_W-1:0] ALU_LTU  = 5'd19;
    localparam logic [ALUOP_W-1:0] ALU_GEU  = 5'd20;

    localparam logic [CSROP_W-1:0] CSR_NONE = 2'd0;
    localparam logic [CSROP_W-1:0] CSR_RW   = 2'd1;
    localparam logic [CSROP_W-1:0] CSR_RS   = 2'd2;
    localparam logic [CSROP_W-1:0] CSR_RC   = 2'd3;

endpackage

// File: rtl/alu_core.sv
// Purely combinational RV64 integer ALU: arithmetic, logic, shifts, word ops
// and branch compares. Unassigned opcodes yield zero result and zero compare.
module alu_core
    import exec_pkg::*;
(
    input  logic [XLEN-1:0]    a,
    input  logic [XLEN-1:0]    b,
    input  logic [ALUOP_W-1:0] op,
    output logic [XLEN-1:0]    result,
    output logic               compare
);

    logic [5:0]  shamt;
    logic [4:0]  shamt_w;
    logic [31:0] word;
    logic        lt_s;
    logic        lt_u;
    logic        eq;

    assign shamt   = b[5:0];
    assign shamt_w = b[4:0];
    assign lt_s    = $signed(a) < $signed(b);
    assign lt_u    = a < b;
    assign eq      = a == b;

    // 32-bit intermediate shared by all W ops before sign extension.
    always_comb begin
        word = 32'd0;
        case (op)
            ALU_ADDW: word = a[31:0] + b[31:0];
            ALU_SUBW: word = a[31:0] - b[31:0];
            ALU_SLLW: word = a[31:0] << shamt_w;
            ALU_SRLW: word = a[31:0] >> shamt_w;
            ALU_SRAW: word = $signed(a[31:0]) >>> shamt_w;
            default:  word = 32'd0;
        endcase
    end

    always_comb begin
        result  = '0;
        compare = 1'b0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW:
                result = {{(XLEN-32){word[31]}}, word};
            ALU_EQ:   compare = eq;
            ALU_NE:   compare = ~eq;
            ALU_LT:   compare = lt_s;
            ALU_GE:   compare = ~lt_s;
            ALU_LTU:  compare = lt_u;
            ALU_GEU:  compare = ~lt_u;
            default: begin
                result  = '0;
                compare = 1'b0;
            end
        endcase
        if (op >= ALU_EQ && op <= ALU_GEU) begin
            result = {{(XLEN-1){1'b0}}, compare};
        end
    end

endmodule

// File: rtl/exec_alu_csr_unit.sv
// Registered execute stage: ALU plus CSR read-modify-write, one-cycle latency.
// in_valid_i qualifies inputs each cycle; out_valid_o follows it one edge later. No backpressure.
module exec_alu_csr_unit
    import exec_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    input  logic [XLEN-1:0]    alu_a_i,
    input  logic [XLEN-1:0]    alu_b_i,
    input  logic [ALUOP_W-1:0] alu_op_i,
    input  logic [XLEN-1:0]    rs1_data_i,
    input  logic [XLEN-1:0]    imm_CSR_i,
    input  logic               isNeedimmCSR_i,
    input  logic [XLEN-1:0]    csr_data_i,
    input  logic [CSROP_W-1:0] csr_op_i,
    output logic               out_valid_o,
    output logic [XLEN-1:0]    alu_out,
    output logic               compare_out,
    output logic [XLEN-1:0]    csr_exe_result,
    output logic               csr_exe_valid
);

    logic [XLEN-1:0] alu_result;
    logic            alu_compare;
    logic [XLEN-1:0] csr_src;
    logic [XLEN-1:0] csr_result;
    logic            csr_valid;
    logic            unused_imm_bits;

    // Only the 5-bit zimm field of the immediate carries meaning.
    assign unused_imm_bits = ^imm_CSR_i[XLEN-1:5];

    alu_core u_alu_core (
        .a       (alu_a_i),
        .b       (alu_b_i),
        .op      (alu_op_i),
        .result  (alu_result),
        .compare (alu_compare)
    );

    assign csr_src = isNeedimmCSR_i ? {{(XLEN-5){1'b0}}, imm_CSR_i[4:0]} : rs1_data_i;

    always_comb begin
        csr_result = '0;
        csr_valid  = 1'b0;
        case (csr_op_i)
            CSR_RW: begin
                csr_result = csr_src;
                csr_valid  = 1'b1;
            end
            CSR_RS: begin
                csr_result = csr_data_i | csr_src;
                csr_valid  = 1'b1;
            end
            CSR_RC: begin
                csr_result = csr_data_i & ~csr_src;
                csr_valid  = 1'b1;
            end
            default: begin
                csr_result = '0;
                csr_valid  = 1'b0;
            end
        endcase
    end

    // Results hold across idle cycles; only the valid flag drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o    <= 1'b0;
            alu_out        <= '0;
            compare_out    <= 1'b0;
            csr_exe_result <= '0;
            csr_exe_valid  <= 1'b0;
        end else begin
            out_valid_o <= in_valid_i;
            if (in_valid_i) begin
                alu_out        <= alu_result;
                compare_out    <= alu_compare;
                csr_exe_result <= csr_result;
                csr_exe_valid  <= csr_valid;
            end
        end
    end

endmodule

// File: tb/tb_exec_alu_csr_unit.sv
// Self-checking bench for exec_alu_csr_unit: directed corner cases then random traffic vs a behavioural model.
module tb_exec_alu_csr_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_i = 1'b0;
    logic [63:0] alu_a_i = '0;
    logic [63:0] alu_b_i = '0;
    logic [4:0]  alu_op_i = '0;
    logic [63:0] rs1_data_i = '0;
    logic [63:0] imm_CSR_i = '0;
    logic        isNeedimmCSR_i = 1'b0;
    logic [63:0] csr_data_i = '0;
    logic [1:0]  csr_op_i = '0;
    logic        out_valid_o;
    logic [63:0] alu_out;
    logic        compare_out;
    logic [63:0] csr_exe_result;
    logic        csr_exe_valid;

    typedef struct {
        logic        v;
        logic [63:0] alu;
        logic        cmp;
        logic [63:0] csr;
        logic        csrv;
    } exp_t;

    exp_t exp_q[$];
    exp_t held = '{v: 1'b0, alu: 64'd0, cmp: 1'b0, csr: 64'd0, csrv: 1'b0};
    int   checks = 0;
    int   errors = 0;

    exec_alu_csr_unit dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid_i),
        .alu_a_i        (alu_a_i),
        .alu_b_i        (alu_b_i),
        .alu_op_i       (alu_op_i),
        .rs1_data_i     (rs1_data_i),
        .imm_CSR_i      (imm_CSR_i),
        .isNeedimmCSR_i (isNeedimmCSR_i),
        .csr_data_i     (csr_data_i),
        .csr_op_i       (csr_op_i),
        .out_valid_o    (out_valid_o),
        .alu_out        (alu_out),
        .compare_out    (compare_out),
        .csr_exe_result (csr_exe_result),
        .csr_exe_valid  (csr_exe_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sext32(input logic [31:0] x);
        logic [63:0] r;
        r = {32'd0, x};
        for (int i = 32; i < 64; i++) r[i] = x[31];
        return r;
    endfunction

    // Reference ALU from instruction semantics: signed order via sign-bit flip, arithmetic shift via complement.
    function automatic void ref_alu(input int op, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] res, output logic cmp);
        logic [63:0] sa, sb;
        logic [31:0] x, y;
        int sh, shw;
        logic slt, sltu, c;
        sa = a ^ 64'h8000_0000_0000_0000;
        sb = b ^ 64'h8000_0000_0000_0000;
        slt = sa < sb;
        sltu = a < b;
        sh = int'(b % 64);
        shw = int'(b % 32);
        x = a[31:0];
        y = b[31:0];
        res = 64'd0;
        cmp = 1'b0;
        c = 1'b0;
        case (op)
            0:  res = a + b;
            1:  res = a - b;
            2:  res = a << sh;
            3:  res = slt ? 64'd1 : 64'd0;
            4:  res = sltu ? 64'd1 : 64'd0;
            5:  res = a ^ b;
            6:  res = a >> sh;
            7:  res = a[63] ? ~((~a) >> sh) : (a >> sh);
            8:  res = a | b;
            9:  res = a & b;
            10: res = sext32(x + y);
            11: res = sext32(x - y);
            12: res = sext32(x << shw);
            13: res = sext32(x >> shw);
            14: res = sext32(x[31] ? ~((~x) >> shw) : (x >> shw));
            15, 16, 17, 18, 19, 20: begin
                case (op)
                    15: c = (a == b);
                    16: c = (a != b);
                    17: c = slt;
                    18: c = !slt;
                    19: c = sltu;
                    default: c = !sltu;
                endcase
                cmp = c;
                res = c ? 64'd1 : 64'd0;
            end
            default: res = 64'd0;
        endcase
    endfunction

    function automatic void ref_csr(input int op, input logic [63:0] rs1, input logic [63:0] imm,
                                    input logic immsel, input logic [63:0] csr,
                                    output logic [63:0] res, output logic v);
        logic [63:0] src;
        src = immsel ? (imm % 32) : rs1;
        v = (op != 0);
        case (op)
            1: res = src;
            2: res = csr | src;
            3: res = csr & ~src;
            default: res = 64'd0;
        endcase
    endfunction

    task automatic drive(input logic rst_v, input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] op, input logic [63:0] rs1, input logic [63:0] imm,
                         input logic immsel, input logic [63:0] csr, input logic [1:0] cop,
                         input string tag);
        exp_t e;
        @(negedge clk);
        rst = rst_v; in_valid_i = v; alu_a_i = a; alu_b_i = b; alu_op_i = op;
        rs1_data_i = rs1; imm_CSR_i = imm; isNeedimmCSR_i = immsel;
        csr_data_i = csr; csr_op_i = cop;
        if (rst_v) begin
            held = '{v: 1'b0, alu: 64'd0, cmp: 1'b0, csr: 64'd0, csrv: 1'b0};
        end else if (v) begin
            ref_alu(int'(op), a, b, held.alu, held.cmp);
            ref_csr(int'(cop), rs1, imm, immsel, csr, held.csr, held.csrv);
            held.v = 1'b1;
        end else begin
            held.v = 1'b0;
        end
        exp_q.push_back(held);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".valid"}, {63'd0, out_valid_o}, {63'd0, e.v});
        check({tag, ".alu"}, alu_out, e.alu);
        check({tag, ".cmp"}, {63'd0, compare_out}, {63'd0, e.cmp});
        check({tag, ".csr"}, csr_exe_result, e.csr);
        check({tag, ".csrv"}, {63'd0, csr_exe_valid}, {63'd0, e.csrv});
    endtask

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h0000_0000_7FFF_FFFF;
            4: return 64'h0000_0000_8000_0000;
            5: return {59'd0, 5'($urandom_range(0, 31))};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset1");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");

        // Known-answer directed checks with literal expectations.
        drive(0, 1, 64'd5, 64'd7, 5'd1, 0, 0, 0, 0, 0, "sub");
        check("sub_lit", alu_out, 64'hFFFF_FFFF_FFFF_FFFE);
        drive(0, 1, 64'h8000_0000_0000_0000, 64'd63, 5'd7, 0, 0, 0, 0, 0, "sra");
        check("sra_lit", alu_out, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(0, 1, 64'h7FFF_FFFF, 64'd1, 5'd10, 0, 0, 0, 0, 0, "addw");
        check("addw_lit", alu_out, 64'hFFFF_FFFF_8000_0000);
        drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd17, 0, 0, 0, 0, 0, "lt");
        check("lt_lit", {63'd0, compare_out}, 64'd1);
        drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd19, 0, 0, 0, 0, 0, "ltu");
        check("ltu_lit", {63'd0, compare_out}, 64'd0);

        // Stream with a bubble, then reset mid-stream with a valid input present.
        drive(0, 1, 64'd100, 64'd23, 5'd0, 64'd9, 0, 0, 64'd1, 2'd1, "s0");
        drive(0, 0, 64'd1, 64'd1, 5'd1, 0, 0, 0, 0, 0, "bubble");
        check("bubble_hold", alu_out, 64'd123);
        drive(0, 1, 64'd3, 64'd4, 5'd0, 0, 0, 0, 0, 0, "s1");
        drive(1, 1, 64'd6, 64'd6, 5'd15, 64'd5, 0, 0, 64'd5, 2'd2, "midrst");
        check("midrst_alu", alu_out, 64'd0);

        drive(0, 1, 0, 0, 5'd0, 64'h0F, 0, 0, 64'hF0, 2'd2, "csr_rs");
        check("csr_rs_lit", csr_exe_result, 64'hFF);
        drive(0, 1, 0, 0, 5'd0, 64'hFFFF, 64'h23, 1, 64'hFF, 2'd3, "csr_rc");
        check("csr_rc_lit", csr_exe_result, 64'hFC);
        drive(0, 1, 0, 0, 5'd0, 64'd0, 0, 0, 64'hAB, 2'd2, "csr_rs_zero");
        check("csr_zero_valid", {63'd0, csr_exe_valid}, 64'd1);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 80), rand64(), rand64(),
                  5'($urandom_range(0, 31)), rand64(), rand64(), 1'($urandom_range(0, 1)),
                  rand64(), 2'($urandom_range(0, 3)), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
